// File: rtl/mult_arbiter_if.sv
// Bundle between the DSP requesters, the shared multiplier and mult_arbiter.
// The master side is the environment (requesters + multiplier), the slave side is the arbiter.
interface mult_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    gnt;
  logic [31:0]         mult_a;
  logic [31:0]         mult_b;
  logic [63:0]         mult_p;
  logic [N_REQ-1:0]    rsp_valid;
  logic [63:0]         rsp_p;
  logic                busy;

  modport master (
    output req, req_a, req_b, mult_p,
    input  gnt, mult_a, mult_b, rsp_valid, rsp_p, busy
  );

  modport slave (
    input  req, req_a, req_b, mult_p,
    output gnt, mult_a, mult_b, rsp_valid, rsp_p, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Shares one pipelined signed 32x32->64 multiplier between N_REQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input logic           clk,
  input logic           rst_n,
  mult_arbiter_if.slave bus
);

  logic [N_REQ-1:0]              req_m;
  logic [N_REQ-1:0][31:0]        a_arr;
  logic [N_REQ-1:0][31:0]        b_arr;
  logic                          gnt_vld;
  logic [IDX_W-1:0]              gnt_idx;
  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][IDX_W-1:0] idx_pipe_q, idx_pipe_d;

  // Requests are ignored while reset is held so gnt stays low.
  assign req_m = rst_n ? bus.req : '0;
  assign a_arr = bus.req_a;
  assign b_arr = bus.req_b;

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req_m[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Walk offsets from the far end so the closest request to ptr wins.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int j = N_REQ-1; j >= 0; j--) begin
      cand = int'(ptr_q) + j;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req_m[IDX_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    bus.gnt    = '0;
    bus.mult_a = '0;
    bus.mult_b = '0;
    if (gnt_vld) begin
      bus.gnt[gnt_idx] = 1'b1;
      bus.mult_a       = a_arr[gnt_idx];
      bus.mult_b       = b_arr[gnt_idx];
    end
  end

  // Tag pipeline mirrors the multiplier depth so each product finds its owner.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    idx_pipe_d    = idx_pipe_q;
    vld_pipe_d[0] = gnt_vld;
    idx_pipe_d[0] = gnt_idx;
    for (int s = 1; s < LATENCY; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      idx_pipe_d[s] = idx_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (vld_pipe_q[LATENCY-1]) bus.rsp_valid[idx_pipe_q[LATENCY-1]] = 1'b1;
  end

  assign bus.rsp_p = bus.mult_p;
  assign bus.busy  = |vld_pipe_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed + randomized bench for mult_arbiter with a 2-stage multiplier model
// and a queue-based reference of arbitration and returning products.
module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  logic [N-1:0] req_v;
  logic [31:0]  a_v [N];
  logic [31:0]  b_v [N];
  logic [63:0]  mp1, mp2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ptr    = 0;

  typedef struct {
    int          due;
    int          idx;
    logic [63:0] p;
  } exp_t;
  exp_t q[$];

  mult_arbiter_if #(.N_REQ(N)) bus ();

  mult_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  // Shared multiplier stand-in, LAT register stages
  always_ff @(posedge clk) begin
    mp1 <= smul(bus.mult_a, bus.mult_b);
    mp2 <= mp1;
  end

  assign bus.req    = req_v;
  assign bus.mult_p = mp2;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign bus.req_a[32*i +: 32] = a_v[i];
    assign bus.req_b[32*i +: 32] = b_v[i];
  end

  function automatic int kx(input int rr, input int fp);
`ifdef MULT_ARB_FIXED_PRIO_EN
    return fp;
`else
    return rr;
`endif
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] t [4];
    t[0] = 32'h8000_0000; t[1] = 32'h7FFF_FFFF; t[2] = 32'h0; t[3] = 32'hFFFF_FFFF;
    if ($urandom_range(3, 0) == 0) return t[$urandom_range(3, 0)];
    return $urandom;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle: check outputs at negedge against the model, then advance the model.
  task automatic step(output int g, input int kg = -1, input int kv = -1,
                      input bit kp_en = 1'b0, input logic [63:0] kp = '0);
    logic [N-1:0] eg, ev;
    logic [31:0]  ea, eb;
    logic [63:0]  ep;
    bit           has_rsp, busy_e;
    exp_t         e;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      ptr = 0;
    end
    g = -1;
    if (rst_n)
      for (int j = N-1; j >= 0; j--)
        if (req_v[(ptr + j) % N]) g = (ptr + j) % N;
    eg = (g >= 0) ? N'(1 << g) : '0;
    ea = (g >= 0) ? a_v[g] : '0;
    eb = (g >= 0) ? b_v[g] : '0;
    ev = '0; ep = '0; has_rsp = 1'b0; busy_e = 1'b0;
    foreach (q[k]) begin
      if (q[k].due == cyc) begin
        ev = N'(1 << q[k].idx);
        ep = q[k].p;
        has_rsp = 1'b1;
      end
      if (q[k].due >= cyc) busy_e = 1'b1;
    end
    chk("gnt", 64'(bus.gnt), 64'(eg));
    chk("mult_a", 64'(bus.mult_a), 64'(ea));
    chk("mult_b", 64'(bus.mult_b), 64'(eb));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (has_rsp) chk("rsp_p", bus.rsp_p, ep);
    chk("busy", 64'(bus.busy), 64'(busy_e));
    if (kg >= 0) chk("gnt_const", 64'(bus.gnt), 64'(1) << kg);
    if (kv >= 0) chk("rsp_valid_const", 64'(bus.rsp_valid), 64'(1) << kv);
    if (kp_en)   chk("rsp_p_const", bus.rsp_p, kp);
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    if (g >= 0) begin
      e.due = cyc + LAT;
      e.idx = g;
      e.p   = smul(a_v[g], b_v[g]);
      q.push_back(e);
`ifndef MULT_ARB_FIXED_PRIO_EN
      ptr = (g + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    req_v = '1;
    for (int i = 0; i < N; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end

    // reset with all requests high, then idle after release
    step(g); step(g);
    rst_n = 1'b1;
    req_v = '0;
    step(g); step(g);

    // round-robin fairness
    req_v = '1;
    for (int k = 0; k < 8; k++) begin
      step(g, kx(k % 4, 0));
      if (g >= 0) begin
        a_v[g] = rnd_op();
        b_v[g] = rnd_op();
      end
    end
    req_v = '0;
    step(g); step(g); step(g);

    // single request, -3 * 7
    a_v[2] = 32'hFFFF_FFFD;
    b_v[2] = 32'd7;
    req_v  = 4'b0100;
    step(g, 2);
    req_v  = '0;
    step(g);
    step(g, -1, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);

    // wrap and skip
    req_v = 4'b0011; step(g, 0);
    req_v = 4'b0010; step(g, 1);
    req_v = 4'b0001; step(g, 0);
    req_v = 4'b1001; step(g, kx(3, 0));
    req_v = '0;
    step(g); step(g);

    // extreme operands back to back
    a_v[0] = 32'h8000_0000; b_v[0] = 32'h8000_0000;
    req_v  = 4'b0001; step(g, 0);
    a_v[1] = 32'h7FFF_FFFF; b_v[1] = 32'h8000_0000;
    req_v  = 4'b0010; step(g, 1);
    req_v  = '0;
    step(g, -1, 0, 1'b1, 64'h4000_0000_0000_0000);
    step(g, -1, 1, 1'b1, 64'hC000_0000_8000_0000);

    // reset while a product is in flight
    req_v = 4'b0100; step(g, 2);
    rst_n = 1'b0;
    req_v = '0;
    step(g);
    rst_n = 1'b1;
    req_v = 4'b1010;
    step(g, 1);
    req_v = '0;
    step(g); step(g); step(g);

    // randomized traffic with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) rst_n = 1'b0;
      if (c == 202) rst_n = 1'b1;
      step(g);
      if (g >= 0) begin
        if ($urandom_range(1, 0) == 1) req_v[g] = 1'b0;
        else begin
          a_v[g] = rnd_op();
          b_v[g] = rnd_op();
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && i != g && $urandom_range(2, 0) == 0) begin
          req_v[i] = 1'b1;
          a_v[i]   = rnd_op();
          b_v[i]   = rnd_op();
        end
      end
    end
    req_v = '0;
    for (int k = 0; k < LAT + 2; k++) step(g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
